// File: rtl/probe_buffer_arbiter.sv
// probe_buffer_arbiter
//   Shares one probe-buffer command port between N_REQ requesters. A round-robin
//   grant accepts one 64-bit command (plus taint) at a time. The command is issued
//   to the probe buffer with a single-cycle write strobe, and the read data/taint
//   is captured PB_LAT cycles later. That result is then returned to the
//   originating requester. Forwarding a power-off command latches a terminal halt.
//
// Ports
//   clock, reset        : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester command handshake (ready is one-hot or 0)
//   req_data/req_taint  : packed command words, requester i at [64i+63:64i]
//   rsp_valid/rsp_ready : per-requester response handshake (valid is one-hot or 0)
//   rsp_data/rsp_taint  : shared response payload
//   pb_wen/pb_write/pb_write_taint : probe-buffer command port
//   pb_read/pb_read_taint          : probe-buffer read-back
//   halted, taint_seen  : sticky status flags
module probe_buffer_arbiter #(
  parameter int          N_REQ         = 4,
  parameter int          PB_LAT        = 1,
  parameter logic [63:0] CMD_MASK      = 64'hFFFF_FFFF_FFFF_0000,
  parameter logic [63:0] CMD_POWER_OFF = 64'hAF1B_608E_883B_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [64*N_REQ-1:0]  req_data,
  input  logic [64*N_REQ-1:0]  req_taint,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [63:0]          rsp_taint,
  output logic                 pb_wen,
  output logic [63:0]          pb_write,
  output logic [63:0]          pb_write_taint,
  input  logic [63:0]          pb_read,
  input  logic [63:0]          pb_read_taint,
  output logic                 halted,
  output logic                 taint_seen
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(PB_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HALT} state_t;

  state_t          state_q;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [63:0]     cmd_q, cmd_taint_q;
  logic [63:0]     rsp_data_q, rsp_taint_q;
  logic            halted_q, taint_seen_q;

  logic [63:0]     req_data_arr  [N_REQ];
  logic [63:0]     req_taint_arr [N_REQ];

  logic            grant_found;
  logic [GW-1:0]   grant_idx;
  logic [GW:0]     cand;

  // Unpack the flat command buses into per-requester words.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi]  = req_data[64*gi +: 64];
      assign req_taint_arr[gi] = req_taint[64*gi +: 64];
    end
  endgenerate

  // Round-robin pick: scan offsets from N_REQ-1 down to 0 so the smallest
  // offset from rr_q (the first valid at or after the pointer) wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req_valid[cand[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    rr_d = (grant_idx == GW'(N_REQ - 1)) ? '0 : grant_idx + GW'(1);
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && !halted_q && grant_found) req_ready[grant_idx] = 1'b1;
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[gnt_q] = 1'b1;
  end

  assign pb_wen         = (state_q == S_ISSUE);
  assign pb_write       = cmd_q;
  assign pb_write_taint = cmd_taint_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_taint      = rsp_taint_q;
  assign halted         = halted_q;
  assign taint_seen     = taint_seen_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      cmd_q        <= '0;
      cmd_taint_q  <= '0;
      rsp_data_q   <= '0;
      rsp_taint_q  <= '0;
      halted_q     <= 1'b0;
      taint_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found && !halted_q) begin
            // The latched command doubles as pb_write, so it holds between commands.
            cmd_q       <= req_data_arr[grant_idx];
            cmd_taint_q <= req_taint_arr[grant_idx];
            gnt_q       <= grant_idx;
            rr_q        <= rr_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CW'(PB_LAT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q   <= pb_read;
            rsp_taint_q  <= pb_read_taint;
            taint_seen_q <= taint_seen_q | (|pb_read_taint);
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready[gnt_q]) begin
            if ((cmd_q & CMD_MASK) == CMD_POWER_OFF) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              state_q  <= S_IDLE;
            end
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_buffer_arbiter.sv
module tb_probe_buffer_arbiter;

  logic          clock;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [255:0]  req_data;
  logic [255:0]  req_taint;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [63:0]   rsp_data;
  logic [63:0]   rsp_taint;
  logic          pb_wen;
  logic [63:0]   pb_write;
  logic [63:0]   pb_write_taint;
  logic [63:0]   pb_read;
  logic [63:0]   pb_read_taint;
  logic          halted;
  logic          taint_seen;

  logic [63:0]   stub_data;
  logic [63:0]   stub_taint;

  int checks = 0;
  int fails  = 0;
  int pb_wen_count = 0;
  int pb_wen_overlap = 0;
  logic pb_wen_prev = 1'b0;

  probe_buffer_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_taint      (req_taint),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_taint      (rsp_taint),
    .pb_wen         (pb_wen),
    .pb_write       (pb_write),
    .pb_write_taint (pb_write_taint),
    .pb_read        (pb_read),
    .pb_read_taint  (pb_read_taint),
    .halted         (halted),
    .taint_seen     (taint_seen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Probe-buffer stub with one cycle of latency: data is valid only in the
  // cycle right after a write strobe, zero otherwise.
  always @(posedge clock) begin
    pb_read       <= pb_wen ? stub_data  : 64'h0;
    pb_read_taint <= pb_wen ? stub_taint : 64'h0;
  end

  always @(negedge clock) begin
    if (pb_wen) begin
      pb_wen_count++;
      if (pb_wen_prev) pb_wen_overlap++;
    end
    pb_wen_prev = pb_wen;
  end

  task automatic set_cmd(input int i, input logic [63:0] d, input logic [63:0] t);
    req_data[64*i +: 64]  = d;
    req_taint[64*i +: 64] = t;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock); #1;
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (pb_wen !== 1'b0) begin fails++; $display("FAIL reset_pb_wen: got %b expected 0", pb_wen); end
    checks++; if (pb_write !== 64'h0 || pb_write_taint !== 64'h0) begin fails++; $display("FAIL reset_pb_write: got %h/%h expected 0/0", pb_write, pb_write_taint); end
    checks++; if (rsp_data !== 64'h0 || rsp_taint !== 64'h0) begin fails++; $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_data, rsp_taint); end
    checks++; if (halted !== 1'b0 || taint_seen !== 1'b0) begin fails++; $display("FAIL reset_flags: got halted=%b taint_seen=%b expected 0/0", halted, taint_seen); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    $display("reset released");
  endtask

  task automatic test_round_robin;
    bit ok;
    int base;
    logic [3:0] exp;
    base = pb_wen_count;
    for (int i = 0; i < 4; i++) set_cmd(i, 64'h1000 + 64'(i), 64'h0);
    stub_data  = 64'h0000_0000_0000_00AA;
    stub_taint = 64'h0;
    req_valid  = 4'hF;
    rsp_ready  = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      wait_ready(ok);
      checks++; if (!ok) begin fails++; $display("FAIL rr_ready_timeout: got no grant expected grant %0d", k % 4); end
      checks++; if (req_ready !== exp) begin fails++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp); end
      @(negedge clock); #1;
      checks++; if (pb_write !== 64'h1000 + 64'(k % 4)) begin fails++; $display("FAIL rr_pb_write_%0d: got %h expected %h", k, pb_write, 64'h1000 + 64'(k % 4)); end
      wait_rsp(ok);
      checks++; if (rsp_valid !== exp) begin fails++; $display("FAIL rr_rsp_valid_%0d: got %b expected %b", k, rsp_valid, exp); end
      $display("rr command %0d granted to requester %0d", k, k % 4);
      @(negedge clock); #1;
    end
    req_valid = 4'h0;
    rsp_ready = 4'h0;
    @(negedge clock); #1;
    checks++; if (pb_wen_count - base !== 8) begin fails++; $display("FAIL rr_pb_wen_pulses: got %0d expected 8", pb_wen_count - base); end
    checks++; if (pb_wen_overlap !== 0) begin fails++; $display("FAIL rr_pb_wen_overlap: got %0d expected 0", pb_wen_overlap); end
  endtask

  task automatic test_single;
    int base;
    base = pb_wen_count;
    set_cmd(0, 64'h0000_0000_0000_1234, 64'h0);
    stub_data  = 64'h0000_0000_DEAD_BEEF;
    stub_taint = 64'h0;
    req_valid  = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    @(negedge clock); #1;
    req_valid = 4'b0000;
    checks++; if (pb_wen !== 1'b1 || pb_write !== 64'h1234) begin fails++; $display("FAIL single_issue: got wen=%b write=%h expected 1/1234", pb_wen, pb_write); end
    @(negedge clock); #1;
    checks++; if (rsp_valid !== 4'b0 || pb_wen !== 1'b0) begin fails++; $display("FAIL single_wait: got rsp_valid=%b wen=%b expected 0000/0", rsp_valid, pb_wen); end
    @(negedge clock); #1;
    checks++; if (rsp_valid !== 4'b0001) begin fails++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
    checks++; if (rsp_data !== 64'hDEAD_BEEF || rsp_taint !== 64'h0) begin fails++; $display("FAIL single_rsp_data: got %h/%h expected deadbeef/0", rsp_data, rsp_taint); end
    rsp_ready = 4'b0001;
    @(negedge clock); #1;
    rsp_ready = 4'b0000;
    checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL single_rsp_done: got %b expected 0000", rsp_valid); end
    checks++; if (pb_wen_count - base !== 1) begin fails++; $display("FAIL single_pb_wen_pulses: got %0d expected 1", pb_wen_count - base); end
    $display("single command from requester 0 returned %h", rsp_data);
  endtask

  task automatic test_taint;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      set_cmd(1, 64'h55 + 64'(pass), 64'h0);
      stub_data  = 64'hA5A5 + 64'(pass);
      stub_taint = (pass == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      req_valid  = 4'b0010;
      #1;
      @(negedge clock); #1;
      req_valid = 4'b0000;
      wait_rsp(ok);
      checks++; if (!ok) begin fails++; $display("FAIL taint_rsp_timeout_%0d: got no response expected rsp_valid", pass); end
      checks++; if (rsp_data !== 64'hA5A5 + 64'(pass)) begin fails++; $display("FAIL taint_rsp_data_%0d: got %h expected %h", pass, rsp_data, 64'hA5A5 + 64'(pass)); end
      checks++; if (rsp_taint !== ((pass == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0)) begin fails++; $display("FAIL taint_rsp_taint_%0d: got %h", pass, rsp_taint); end
      checks++; if (taint_seen !== 1'b1) begin fails++; $display("FAIL taint_seen_%0d: got %b expected 1", pass, taint_seen); end
      rsp_ready = 4'b0010;
      @(negedge clock); #1;
      rsp_ready = 4'b0000;
      $display("taint command %0d returned taint %h", pass, rsp_taint);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    set_cmd(3, 64'h33, 64'h0);
    stub_data  = 64'h0123_4567_89AB_CDEF;
    stub_taint = 64'h0;
    req_valid  = 4'b1011;
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    @(negedge clock); #1;
    wait_rsp(ok);
    checks++; if (rsp_valid !== 4'b1000) begin fails++; $display("FAIL bp_rsp_valid: got %b expected 1000", rsp_valid); end
    rsp_ready = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL bp_hold_%0d: got %b/%h expected 1000/0123456789abcdef", c, rsp_valid, rsp_data); end
      checks++; if (req_ready !== 4'b0 || pb_wen !== 1'b0) begin fails++; $display("FAIL bp_no_grant_%0d: got ready=%b wen=%b expected 0000/0", c, req_ready, pb_wen); end
    end
    req_valid = 4'b0000;
    rsp_ready = 4'b1000;
    @(negedge clock); #1;
    rsp_ready = 4'b0000;
    checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL bp_release: got %b expected 0000", rsp_valid); end
    $display("backpressured command from requester 3 returned %h", rsp_data);
  endtask

  task automatic test_reset_in_wait;
    set_cmd(1, 64'h77, 64'h0);
    stub_data  = 64'h9999;
    stub_taint = 64'h0;
    req_valid  = 4'b0010;
    #1;
    @(negedge clock); #1;
    req_valid = 4'b0000;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (pb_wen !== 1'b0 || rsp_valid !== 4'b0 || req_ready !== 4'b0) begin fails++; $display("FAIL rstw_handshake: got wen=%b rsp_valid=%b ready=%b expected 0", pb_wen, rsp_valid, req_ready); end
    checks++; if (pb_write !== 64'h0 || pb_write_taint !== 64'h0) begin fails++; $display("FAIL rstw_pb_write: got %h/%h expected 0/0", pb_write, pb_write_taint); end
    checks++; if (rsp_data !== 64'h0 || rsp_taint !== 64'h0) begin fails++; $display("FAIL rstw_rsp_data: got %h/%h expected 0/0", rsp_data, rsp_taint); end
    checks++; if (taint_seen !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL rstw_flags: got taint_seen=%b halted=%b expected 0/0", taint_seen, halted); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rstw_next_grant: got %b expected 0001", req_ready); end
    req_valid = 4'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock); #1;
      checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rstw_no_rsp_%0d: got %b expected 0000", c, rsp_valid); end
    end
    $display("reset during WAIT aborted the command");
  endtask

  task automatic test_halt;
    bit ok;
    int base;
    int viol;
    set_cmd(2, 64'hAF1B_608E_883B_0001, 64'h0);
    stub_data  = 64'h0;
    stub_taint = 64'h0;
    req_valid  = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL halt_grant: got %b expected 0100", req_ready); end
    @(negedge clock); #1;
    req_valid = 4'b0000;
    wait_rsp(ok);
    checks++; if (rsp_valid !== 4'b0100 || halted !== 1'b0) begin fails++; $display("FAIL halt_rsp: got rsp_valid=%b halted=%b expected 0100/0", rsp_valid, halted); end
    rsp_ready = 4'b0100;
    @(negedge clock); #1;
    checks++; if (halted !== 1'b1 || rsp_valid !== 4'b0) begin fails++; $display("FAIL halt_set: got halted=%b rsp_valid=%b expected 1/0000", halted, rsp_valid); end
    for (int i = 0; i < 4; i++) set_cmd(i, 64'h100 + 64'(i), 64'h0);
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    base = pb_wen_count;
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock); #1;
      if (req_ready !== 4'b0 || rsp_valid !== 4'b0) viol++;
    end
    checks++; if (viol !== 0) begin fails++; $display("FAIL halt_no_grant: got %0d violating cycles expected 0", viol); end
    checks++; if (pb_wen_count - base !== 0) begin fails++; $display("FAIL halt_no_pb_wen: got %0d pulses expected 0", pb_wen_count - base); end
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_sticky: got %b expected 1", halted); end
    req_valid = 4'h0;
    rsp_ready = 4'h0;
    $display("power-off command from requester 2 halted the arbiter");
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 4'h0;
    rsp_ready  = 4'h0;
    req_data   = '0;
    req_taint  = '0;
    stub_data  = 64'h0;
    stub_taint = 64'h0;
    @(negedge clock); #1;
    test_reset;
    test_round_robin;
    test_single;
    test_taint;
    test_backpressure;
    test_reset_in_wait;
    test_halt;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/probe_buffer_arbiter.md
# probe_buffer_arbiter

Round-robin arbiter and sequencer that shares one probe-buffer command port between `N_REQ` requesters (harts, fuzz-harness agents). It accepts one 64-bit command at a time over a valid/ready handshake, drives a single-cycle write strobe into the probe buffer, and captures the returned data and taint after a fixed latency. It then returns the captured data to the originating requester. It sits between the requesters' probe MMIO shims and the probe buffer black box, and latches a terminal halt when a power-off command is forwarded.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `PB_LAT`, 1: cycles from `pb_wen` to valid `pb_read`, ≥1.
- `CMD_MASK`, 64'hFFFF_FFFF_FFFF_0000: opcode mask applied to command words.
- `CMD_POWER_OFF`, 64'hAF1B_608E_883B_0000: opcode that triggers the halt.

Ports:
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  N_REQ  per-requester command valid.
- `req_ready`  output  N_REQ  per-requester accept; one-hot or zero.
- `req_data`  input  64*N_REQ  command words; requester i occupies bits [64i+63:64i].
- `req_taint`  input  64*N_REQ  taint of command words, same packing.
- `rsp_valid`  output  N_REQ  per-requester response valid; one-hot or zero.
- `rsp_ready`  input  N_REQ  per-requester response accept.
- `rsp_data`  output  64  response data, shared across requesters.
- `rsp_taint`  output  64  response taint, shared across requesters.
- `pb_wen`  output  1  probe-buffer write strobe.
- `pb_write`  output  64  probe-buffer command word.
- `pb_write_taint`  output  64  probe-buffer command taint.
- `pb_read`  input  64  probe-buffer read data.
- `pb_read_taint`  input  64  probe-buffer read taint.
- `halted`  output  1  sticky; set once a power-off command has completed.
- `taint_seen`  output  1  sticky; set when any captured `pb_read_taint` is nonzero.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HALT.
- IDLE
  - If `halted`=0 and any `req_valid` is high: grant the first valid requester at or after pointer `rr` (wrapping modulo N_REQ).
  - `req_ready[g]` is high combinationally in IDLE for the granted requester only.
  - On the handshake: latch the command word, its taint and `g`; set `rr` to (g+1) mod N_REQ; go to ISSUE.
- ISSUE: drive `pb_wen`=1 with the latched word and taint for exactly one cycle; load a latency counter with `PB_LAT`-1; go to WAIT.
- WAIT
  - When the counter is 0: capture `pb_read`/`pb_read_taint` into the response registers and OR the taint reduction into `taint_seen`; go to RESP.
  - Otherwise decrement the counter.
  - With `PB_LAT`=1, WAIT lasts one cycle.
- RESP
  - Hold `rsp_valid[g]`=1 with stable data until `rsp_ready[g]`.
  - On acceptance: if (latched word & CMD_MASK)==CMD_POWER_OFF, set `halted` and go to HALT; otherwise go to IDLE.
- HALT: terminal. All `req_ready`, `rsp_valid` and `pb_wen` are 0. Only reset exits.
- `rsp_ready` of non-granted requesters is ignored. `req_valid` arriving outside IDLE waits.
- Simultaneous requests: exactly one is granted per command; no requester waits more than N_REQ-1 grants.

## Timing
- Reset (asynchronous assert, removal synchronised by the parent): state IDLE, `rr`=0, and all outputs 0, including `halted`, `taint_seen`, `pb_write`, `pb_write_taint`, `rsp_data` and `rsp_taint`.
- Reset mid-transaction aborts the transaction. No response is delivered after reset.
- Latency from the accept edge to `rsp_valid`: 1 (ISSUE) + `PB_LAT` cycles. With default parameters, accept at cycle 0 gives `pb_wen` in cycle 1, capture at the end of cycle 2, and `rsp_valid` in cycle 3.
- Throughput: one command per (3 + `PB_LAT`) cycles with `rsp_ready` held high.
- `pb_write` and `pb_write_taint` hold the last issued value between commands.

## Test plan
- Single requester 0 sends 64'h0000_0000_0000_1234; stub returns 64'hDEAD_BEEF → exactly one `pb_wen` pulse; `rsp_valid[0]` appears 3 cycles after accept with `rsp_data`=64'hDEAD_BEEF and `rsp_taint`=0.
- All four requesters valid continuously for 8 commands → grant order 0,1,2,3,0,1,2,3, and no `pb_wen` overlap.
- Stub returns taint 64'hFFFF_FFFF_FFFF_FFFF → `rsp_taint` is all ones and `taint_seen` rises and stays set across later clean responses.
- Requester 2 sends 64'hAF1B_608E_883B_0001 → after `rsp_ready[2]`, `halted`=1 and no further `req_ready` or `pb_wen` occurs over 100 cycles despite valid requests.
- `rsp_ready` is held low for 10 cycles → `rsp_valid` and `rsp_data` stay stable and no new grant is made.
- Reset is asserted in WAIT → all outputs read 0 immediately; after release, the next grant goes to requester 0.
